pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the RISC-V core. It is the successor of the fixed-field stage registers between ID/EX and later stages.
- Carries an opaque payload (DATA_W) plus a control field (CTRL_W) across a valid/ready handshake.
- Optional 2-entry skid buffer so that in_ready has no combinational path from out_ready.
- Adds synchronous flush (trap/branch) and a control-kill bubble for load-use hazards; the kill clears masked control bits while the payload is held.

Parameters:
- DATA_W, 160, payload width (pc, operands, imm, instr, csr fields, ...).
- CTRL_W, 24, control-field width (regWEn, MemW, memRead, WBSel, ALUSel, ...).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CTRL_KILL_MASK, {CTRL_W{1'b1}}, control bits forced to 0 by kill_ctrl.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush (trap or branch redirect)
- kill_ctrl  in  1  load-use bubble: clear masked ctrl bits of the held main entry
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main entry payload
- out_ctrl  out  CTRL_W  main entry control
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY, ONE, TWO. TWO is only reachable when SKID=1. out_valid = (state != EMPTY). occupancy = 0 / 1 / 2.
- Reset (reset=0, asynchronous):
  - state EMPTY.
  - main and skid data/ctrl cleared to 0.
  - out_valid=0, occupancy=0, in_ready=0.
  - in_ready goes to 1 on the first posedge after reset is released.
- SKID=1 transitions:
  - EMPTY: in_fire -> main<=in, ONE.
  - ONE: in_fire & out_fire -> main<=in, stay ONE; in_fire & !out_fire -> skid<=in, TWO; !in_fire & out_fire -> EMPTY.
  - TWO: out_fire -> main<=skid, ONE; otherwise hold.
  - in_ready is a register equal to (next_state != TWO). It must not depend combinationally on out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational). No skid register is built.
  - EMPTY/ONE transitions as above; in_fire with out_fire reloads main.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 entry/cycle when out_ready is held high.
- Data and ctrl of a held entry never change, except when kill_ctrl applies.
- flush (highest priority, synchronous):
  - Next state EMPTY; main/skid data and ctrl <= 0.
  - An in_fire in the same cycle is dropped. An out_fire in the same cycle still counts as consumed by downstream.
  - in_ready = 1 in the cycle after the flush.
- kill_ctrl (ignored when flush=1):
  - Applied to the main entry as it stands at the end of the cycle: held, newly loaded, or promoted from skid.
  - main_ctrl <= main_ctrl & ~CTRL_KILL_MASK; data untouched; out_valid unchanged.
  - The skid entry is never killed. kill_ctrl in EMPTY with no in_fire has no effect.
- Multi-cycle hold (e.g. divider busy): downstream holds out_ready=0. The entry is kept intact, with no control clearing unless kill_ctrl is asserted.
- Ordering: strict FIFO; the skid entry always follows main.
- No entry is lost or duplicated under any in_valid/out_ready pattern.

Test Plan:
- Reset mid-operation: load data=0xA5 (state ONE), assert reset=0 between edges -> out_valid=0 and out_data=0 immediately; in_ready=0 until the first edge after release, then 1.
- Streaming, SKID=1: out_ready=1, inputs 1..8 on consecutive cycles -> outputs 1..8 on cycles +1..+8, occupancy never exceeds 1, no bubbles.
- Backpressure: out_ready=0 while entries 0x10 and 0x11 arrive -> occupancy=2, in_ready=0; then out_ready=1 -> 0x10, then 0x11, in order, in_ready re-asserts one cycle later.
- Flush with in_fire in ONE: flush=1, in_valid=1 (data 0x22) -> next cycle out_valid=0, out_ctrl=0, 0x22 never appears at the output.
- Load-use kill: main ctrl=0xFFFFFF, CTRL_KILL_MASK=0x000007, kill_ctrl=1 with out_ready=0 -> ctrl=0xFFFFF8, data unchanged, out_valid=1.
- Kill and promote: state TWO, out_fire with kill_ctrl=1 -> the promoted skid entry has masked bits cleared and the consumed entry was unaltered. Also check SKID=0 with random in_valid/out_ready over 1000 cycles -> scoreboard matches.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : Valid/ready handshake bundle carrying an opaque payload and
//                a control field between two pipeline stages.
//                  valid : producer has an entry on data/ctrl
//                  ready : consumer can take the entry this cycle
//                  data  : payload (DATA_W bits)
//                  ctrl  : control field (CTRL_W bits)
//                master = producer side, slave = consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 24
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic inter-stage pipeline register. Moves one entry
//                (payload + control) per handshake, with an optional second
//                (skid) entry so the upstream ready is a pure register.
//                Supports a synchronous flush and a control-kill bubble.
//
//  Ports
//    clk        in   clock
//    reset      in   asynchronous, active-low reset
//    flush      in   synchronous flush, drops everything held and incoming
//    kill_ctrl  in   clear CTRL_KILL_MASK bits of the main entry
//    in_if      slv  upstream handshake (valid/data/ctrl in, ready out)
//    out_if     mst  downstream handshake (valid/data/ctrl out, ready in)
//    occupancy  out  number of entries held: 0, 1 or 2
//
//  Parameters
//    DATA_W          payload width
//    CTRL_W          control-field width
//    SKID            1: two entries, registered in_ready
//                    0: one entry, combinational in_ready
//    CTRL_KILL_MASK  control bits forced to 0 by kill_ctrl
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W         = 160,
    parameter int                CTRL_W         = 24,
    parameter int                SKID           = 1,
    parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = {CTRL_W{1'b1}}
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              flush,
    input  wire              kill_ctrl,
    pipe_stage_reg_if.slave  in_if,
    pipe_stage_reg_if.master out_if,
    output logic [1:0]       occupancy
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_if.valid & in_ready;
    assign out_fire  = out_valid & out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_data_q;
    assign out_if.ctrl  = main_ctrl_q;
    assign occupancy    = state_q;

    // ------------------------------------------------------------------
    // Next-state and next-entry logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // An out_fire this cycle is still consumed downstream; an
            // in_fire this cycle is simply dropped.
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_if.data;
                        main_ctrl_d = in_if.ctrl;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_if.data;
                        main_ctrl_d = in_if.ctrl;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; without one,
                        // in_ready is low whenever main is held and stalled.
                        if (SKID != 0) begin
                            skid_data_d = in_if.data;
                            skid_ctrl_d = in_if.ctrl;
                            state_d     = ST_TWO;
                        end
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low in TWO, so no new entry can arrive.
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase

            // Kill acts on whatever ends up in main this cycle (held, newly
            // loaded or promoted); the skid entry is left alone.
            if (kill_ctrl && (state_d != ST_EMPTY)) begin
                main_ctrl_d = main_ctrl_d & ~CTRL_KILL_MASK;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main entry and state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // Skid entry / ready generation
    // ------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                    in_ready_q  <= 1'b0;
                end else begin
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    // Registered from next state so in_ready never sees
                    // out_ready combinationally.
                    in_ready_q  <= (state_d != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            // Holds in_ready low from reset until the first clock edge.
            logic rst_done_q;
            logic w_unused_skid;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rst_done_q <= 1'b0;
                end else begin
                    rst_done_q <= 1'b1;
                end
            end

            assign skid_data_q   = '0;
            assign skid_ctrl_q   = '0;
            assign w_unused_skid = ^{skid_data_d, skid_ctrl_d};
            assign in_ready      = rst_done_q & (~out_valid | out_if.ready);
        end
    endgenerate

endmodule
`default_nettype wire
